// File: rtl/sa_pkg.sv
// Shared types and defaults for the systolic array feed controller.
package sa_pkg;

  localparam int unsigned SA_N    = 4;
  localparam int unsigned SA_DW   = 8;
  localparam int unsigned SA_KMAX = 16;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    DONE
  } sa_state_t;

  // Cycles between the last read strobe and stable results in the far-corner PE.
  function automatic int unsigned drain_len(input int unsigned n);
    return 2 * n;
  endfunction

endpackage

// File: rtl/systolic_feed_ctrl_if.sv
// Command, operand-buffer and array-edge signals of the systolic feed controller.
interface systolic_feed_ctrl_if
  import sa_pkg::*;
#(
  parameter int unsigned N  = SA_N,
  parameter int unsigned DW = SA_DW,
  parameter int unsigned KW = $clog2(SA_KMAX + 1)
) ();

  logic          cmd_valid;
  logic          cmd_ready;
  logic [KW-1:0] cmd_k;
  logic          busy;
  logic          rd_en;
  logic [KW-1:0] rd_addr;
  logic [N*DW-1:0] a_rd_data;
  logic [N*DW-1:0] b_rd_data;
  logic          pe_clear;
  logic          pe_start;
  logic [N*DW-1:0] pe_a;
  logic [N-1:0]  pe_a_valid;
  logic [N*DW-1:0] pe_b;
  logic [N-1:0]  pe_b_valid;
  logic          done;

  modport master (
    input  cmd_valid, cmd_k, a_rd_data, b_rd_data,
    output cmd_ready, busy, rd_en, rd_addr, pe_clear, pe_start,
           pe_a, pe_a_valid, pe_b, pe_b_valid, done
  );

  modport slave (
    output cmd_valid, cmd_k, a_rd_data, b_rd_data,
    input  cmd_ready, busy, rd_en, rd_addr, pe_clear, pe_start,
           pe_a, pe_a_valid, pe_b, pe_b_valid, done
  );

endinterface

// File: rtl/sa_skew_line.sv
// Operand skew line: delays one data lane and its valid by DEPTH cycles, zeroing invalid slots.
module sa_skew_line #(
  parameter int unsigned DEPTH = 0,
  parameter int unsigned DW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] data,
  input  logic          valid,
  output logic [DW-1:0] data_dly,
  output logic          valid_dly
);

  if (DEPTH == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
    assign data_dly  = valid ? data : '0;
    assign valid_dly = valid;
  end else begin : g_dly
    logic [DW-1:0]    d_q [DEPTH];
    logic [DEPTH-1:0] v_q;

    // Data is zeroed on entry so an empty slot stays zero along the chain.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) d_q[i] <= '0;
        v_q <= '0;
      end else begin
        d_q[0] <= valid ? data : '0;
        v_q[0] <= valid;
        for (int i = 1; i < DEPTH; i++) begin
          d_q[i] <= d_q[i-1];
          v_q[i] <= v_q[i-1];
        end
      end
    end

    assign data_dly  = d_q[DEPTH-1];
    assign valid_dly = v_q[DEPTH-1];
  end

endmodule

// File: rtl/systolic_feed_ctrl.sv
// Systolic array sequencer: clear, operand fetch with per-lane skew, drain, done pulse.
// Optional busy-cycle counter output perf_cycles when SA_PERF_CNT_EN is defined.
module systolic_feed_ctrl
  import sa_pkg::*;
#(
  parameter int unsigned N    = SA_N,
  parameter int unsigned DW   = SA_DW,
  parameter int unsigned KMAX = SA_KMAX,
  parameter int unsigned KW   = $clog2(KMAX + 1)
) (
  input  logic clk,
  input  logic rst_n,
  systolic_feed_ctrl_if.master bus
`ifdef SA_PERF_CNT_EN
  ,
  output logic [31:0] perf_cycles
`endif
);

  localparam int unsigned DRAIN_LEN = drain_len(N);
  localparam int unsigned CNT_MAX   = (KMAX > DRAIN_LEN) ? KMAX : DRAIN_LEN;
  localparam int unsigned CW        = $clog2(CNT_MAX + 1);

  sa_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [KW-1:0] k_q, k_d;

  logic          cmd_ready_q, cmd_ready_d;
  logic          busy_q, busy_d;
  logic          rd_en_q, rd_en_d;
  logic [KW-1:0] rd_addr_q, rd_addr_d;
  logic          pe_clear_q, pe_clear_d;
  logic          pe_start_q, pe_start_d;
  logic          done_q, done_d;
  logic          op_valid_q;

  // Next state plus the output values that will hold in that state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          k_d     = (bus.cmd_k > KW'(KMAX)) ? KW'(KMAX) : bus.cmd_k;
          cnt_d   = '0;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        cnt_d   = '0;
        state_d = (k_q != '0) ? FEED : DRAIN;
      end
      FEED: begin
        if (cnt_q == CW'(k_q - KW'(1))) begin
          cnt_d   = '0;
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DRAIN: begin
        if (cnt_q == CW'(DRAIN_LEN - 1)) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    cmd_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
    rd_en_d     = (state_d == FEED);
    rd_addr_d   = (state_d == FEED) ? KW'(cnt_d) : '0;
    pe_clear_d  = (state_d == CLEAR);
    pe_start_d  = (state_d == CLEAR) || (state_d == FEED) || (state_d == DRAIN);
    done_d      = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      k_q         <= '0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      pe_clear_q  <= 1'b0;
      pe_start_q  <= 1'b0;
      done_q      <= 1'b0;
      op_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      k_q         <= k_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      pe_clear_q  <= pe_clear_d;
      pe_start_q  <= pe_start_d;
      done_q      <= done_d;
      op_valid_q  <= rd_en_q;
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.busy      = busy_q;
  assign bus.rd_en     = rd_en_q;
  assign bus.rd_addr   = rd_addr_q;
  assign bus.pe_clear  = pe_clear_q;
  assign bus.pe_start  = pe_start_q;
  assign bus.done      = done_q;

  // Row i / column j lanes are delayed by i / j cycles to form the wavefront.
  for (genvar i = 0; i < int'(N); i++) begin : g_skew
    sa_skew_line #(.DEPTH(i), .DW(DW)) u_a_skew (
      .clk       (clk),
      .rst_n     (rst_n),
      .data      (bus.a_rd_data[i*DW +: DW]),
      .valid     (op_valid_q),
      .data_dly  (bus.pe_a[i*DW +: DW]),
      .valid_dly (bus.pe_a_valid[i])
    );
    sa_skew_line #(.DEPTH(i), .DW(DW)) u_b_skew (
      .clk       (clk),
      .rst_n     (rst_n),
      .data      (bus.b_rd_data[i*DW +: DW]),
      .valid     (op_valid_q),
      .data_dly  (bus.pe_b[i*DW +: DW]),
      .valid_dly (bus.pe_b_valid[i])
    );
  end

`ifdef SA_PERF_CNT_EN
  logic [31:0] perf_q;

  // Busy-cycle counter, saturating; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_q <= '0;
    end else if (busy_q && (perf_q != '1)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Directed bench for systolic_feed_ctrl with operand buffers and a 4x4 PE-array model.
module tb_systolic_feed_ctrl;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  systolic_feed_ctrl_if #(.N(4), .DW(8), .KW(5)) bus ();

`ifdef SA_PERF_CNT_EN
  logic [31:0] perf_cycles;
`endif

  systolic_feed_ctrl #(.N(4), .DW(8), .KMAX(16), .KW(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef SA_PERF_CNT_EN
    ,
    .perf_cycles (perf_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Operand buffers with one cycle of read latency.
  logic [31:0] a_mem [16];
  logic [31:0] b_mem [16];

  always @(posedge clk) begin
    if (bus.rd_en) begin
      bus.a_rd_data <= a_mem[bus.rd_addr[3:0]];
      bus.b_rd_data <= b_mem[bus.rd_addr[3:0]];
    end
  end

  // Behavioural 4x4 PE array: A moves right, B moves down, one hop per cycle.
  logic [7:0] a_r  [4][4];
  logic [7:0] b_r  [4][4];
  logic       av_r [4][4];
  logic       bv_r [4][4];
  int         acc  [4][4];

  function automatic logic [7:0] a_at(int r, int c);
    if (c == 0) return bus.pe_a[r*8 +: 8];
    return a_r[r][c-1];
  endfunction
  function automatic logic av_at(int r, int c);
    if (c == 0) return bus.pe_a_valid[r];
    return av_r[r][c-1];
  endfunction
  function automatic logic [7:0] b_at(int r, int c);
    if (r == 0) return bus.pe_b[c*8 +: 8];
    return b_r[r-1][c];
  endfunction
  function automatic logic bv_at(int r, int c);
    if (r == 0) return bus.pe_b_valid[c];
    return bv_r[r-1][c];
  endfunction

  always @(negedge clk) begin
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (bus.pe_clear) begin
          acc[r][c]  <= 0;
          av_r[r][c] <= 1'b0;
          bv_r[r][c] <= 1'b0;
          a_r[r][c]  <= '0;
          b_r[r][c]  <= '0;
        end else if (bus.pe_start) begin
          if (av_at(r, c) && bv_at(r, c))
            acc[r][c] <= acc[r][c] + int'(a_at(r, c)) * int'(b_at(r, c));
          a_r[r][c]  <= a_at(r, c);
          b_r[r][c]  <= b_at(r, c);
          av_r[r][c] <= av_at(r, c);
          bv_r[r][c] <= bv_at(r, c);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns in the CLEAR cycle (cycle T+1 after accept edge T).
  task automatic send(input logic [4:0] k);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_k     = k;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int i;
    i = 0;
    while (!bus.done && i < budget) begin
      step();
      i++;
    end
    if (!bus.done) check("done_timeout", 128'(bus.done), 128'(1));
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ready"}, 128'(bus.cmd_ready), 128'(1));
    check({tag, "_outs"}, {bus.busy, bus.rd_en, bus.rd_addr, bus.pe_clear, bus.pe_start,
                           bus.pe_a, bus.pe_a_valid, bus.pe_b, bus.pe_b_valid, bus.done}, 128'(0));
  endtask

  initial begin
    logic [31:0] exp_a, exp_b;
    logic [3:0]  exp_av, exp_bv;
    int c1, c2, cd, nrd, last_addr, seen;

    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_k     = '0;
    for (int k = 0; k < 16; k++) begin
      a_mem[k] = '0;
      b_mem[k] = '0;
    end
    #23;
    check_quiet("reset");
`ifdef SA_PERF_CNT_EN
    check("reset_perf", 128'(perf_cycles), 128'(0));
`endif
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // K=3 control timeline
    send(5'd3);
    for (int n = 1; n <= 14; n++) begin
      logic rd;
      if (n > 1) step();
      rd = (n >= 2 && n <= 4);
      check($sformatf("k3_cyc%0d", n),
            {bus.pe_clear, bus.rd_en, bus.rd_addr, bus.pe_start, bus.done, bus.cmd_ready, bus.busy},
            {(n == 1), rd, rd ? 5'(n - 2) : 5'd0, (n <= 12), (n == 13), (n == 14), (n != 14)});
    end
`ifdef SA_PERF_CNT_EN
    check("k3_perf", 128'(perf_cycles), 128'(13));
`endif

    // K=1 skew: A lanes {4,3,2,1}, B lanes {8,7,6,5}
    a_mem[0] = 32'h0403_0201;
    b_mem[0] = 32'h0807_0605;
    send(5'd1);
    for (int n = 1; n <= 11; n++) begin
      if (n > 1) step();
      exp_a = '0; exp_b = '0; exp_av = '0; exp_bv = '0;
      for (int i = 0; i < 4; i++) begin
        if (n == 3 + i) begin
          exp_a[i*8 +: 8] = 8'(i + 1);
          exp_b[i*8 +: 8] = 8'(i + 5);
          exp_av[i] = 1'b1;
          exp_bv[i] = 1'b1;
        end
      end
      check($sformatf("skew_a_cyc%0d", n), {bus.pe_a, bus.pe_a_valid}, {exp_a, exp_av});
      check($sformatf("skew_b_cyc%0d", n), {bus.pe_b, bus.pe_b_valid}, {exp_b, exp_bv});
    end
    step();

    // Full matrix: A = I4, B[k][j] = 4k+j+1, so C = B
    for (int k = 0; k < 4; k++) begin
      a_mem[k] = 32'd1 << (k * 8);
      for (int j = 0; j < 4; j++) b_mem[k][j*8 +: 8] = 8'(4 * k + j + 1);
    end
    send(5'd4);
    wait_done(30);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        check($sformatf("mat_c%0d%0d", r, c), 128'(acc[r][c]), 128'(4 * r + c + 1));
    step(); step(); step();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        check($sformatf("mat_hold_c%0d%0d", r, c), 128'(acc[r][c]), 128'(4 * r + c + 1));

    // K=0: CLEAR, 8 DRAIN cycles, DONE, no reads
    send(5'd0);
    for (int n = 1; n <= 11; n++) begin
      if (n > 1) step();
      check($sformatf("k0_cyc%0d", n),
            {bus.pe_clear, bus.rd_en, bus.pe_start, bus.done, bus.cmd_ready},
            {(n == 1), 1'b0, (n <= 9), (n == 10), (n == 11)});
    end

    // cmd_valid held through a command: second accept only after done
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_k     = 5'd2;
    c1 = -1; c2 = -1; cd = -1;
    for (int c = 1; c <= 30; c++) begin
      step();
      if (bus.pe_clear) begin
        if (c1 < 0) c1 = c;
        else if (c2 < 0) c2 = c;
      end
      if (bus.done && cd < 0) cd = c;
      if (c2 > 0) break;
    end
    bus.cmd_valid = 1'b0;
    check("hold_first_clear", 128'(c1), 128'(1));
    check("hold_done", 128'(cd), 128'(12));
    check("hold_second_clear", 128'(c2), 128'(14));
    wait_done(30);
    step();

    // cmd_k=20 saturates to 16 reads
    send(5'd20);
    nrd = 0;
    last_addr = -1;
    for (int i = 0; i < 60 && !bus.done; i++) begin
      step();
      if (bus.rd_en) begin
        nrd++;
        last_addr = int'(bus.rd_addr);
      end
    end
    check("sat_done", 128'(bus.done), 128'(1));
    check("sat_reads", 128'(nrd), 128'(16));
    check("sat_last_addr", 128'(last_addr), 128'(15));
    step();

    // Reset during FEED at rd_addr=2
    send(5'd8);
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.rd_en && bus.rd_addr == 5'd2) break;
    end
    check("mid_addr2", {bus.rd_en, bus.rd_addr}, {1'b1, 5'd2});
    #2;
    rst_n = 1'b0;
    #1;
    check_quiet("mid_rst");
`ifdef SA_PERF_CNT_EN
    check("mid_rst_perf", 128'(perf_cycles), 128'(0));
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.done) seen = 1;
    end
    check("mid_no_done", 128'(seen), 128'(0));
    check("mid_idle", {bus.cmd_ready, bus.busy}, {1'b1, 1'b0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
